ex_stage_hs: RTL and testbench
==============================

EX_STAGE_HS -- requirements
Module: ex_stage_hs

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; the legal values are 32 and 64.
REQ-002 The block SHALL have parameter NFWD, default 2, giving the number of forwarding sources, each with fixed priority where the lowest index wins.
REQ-003 The block SHALL have parameter BP_TAG_W, default 10, giving the branch-predictor tag width, taken as pc[BP_TAG_W-1:0].
REQ-004 The block SHALL have the following ports, clock and reset first:
  clk  in  1  clock
  rst  in  1  reset, asynchronous, active-high
  in_valid / in_ready  in / out  1 / 1  upstream handshake
  in_pc  in  XLEN  instruction PC
  in_op  in  5  ALU opcode
  in_rd, in_rs1, in_rs2  in  5 each  register indices
  in_opr1, in_opr2  in  XLEN each  register-file operands
  in_val  in  XLEN  immediate / store data
  in_wb_e, in_br_e, in_jp_e  in  1 each  writeback, branch and jump flags
  in_mem_e, in_mem_len  in  2 each  memory control, passed through
  fwd_vld  in  NFWD  forward source valid
  fwd_idx  in  5*NFWD  forward destination indices
  fwd_val  in  XLEN*NFWD  forward values
  flush  in  1  kill all in-flight work
  out_valid / out_ready  out / in  1 / 1  downstream handshake
  out_ans, out_val  out  XLEN each  result and passthrough value
  out_rd  out  5  destination index
  out_wb_e  out  1  writeback enable
  out_mem_e, out_mem_len  out  2 each  memory control
  redir_e  out  1  redirect pulse
  redir_pc  out  XLEN  redirect target
  bp_we  out  1  predictor update pulse
  bp_tag  out  BP_TAG_W  predictor tag
  bp_taken  out  1  resolved branch direction
  ex_fwd_idx  out  5  own forward index
  ex_fwd_val  out  XLEN  own forward value
  busy  out  1  multiply in progress

Function
REQ-005 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-006 An instruction SHALL be accepted only on a clock edge where in_valid && in_ready is true.
REQ-007 Operand A SHALL be selected as follows: if in_rs1==0, use in_opr1; otherwise use the fwd_val of the lowest-index source with fwd_vld=1 and a matching fwd_idx; otherwise use in_opr1. Operand B SHALL be selected the same way from in_rs2 and in_opr2.
REQ-008 Opcodes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU, 16 MUL; codes 17-31 SHALL produce 0.
REQ-009 Shift amounts SHALL use B[$clog2(XLEN)-1:0]; compare opcodes SHALL produce 0 or 1; arithmetic SHALL wrap modulo 2^XLEN; MUL SHALL return the low XLEN bits.
REQ-010 Opcodes 0-15 SHALL have latency 1: the result is registered at the accept edge and out_valid=1 on the following cycle.
REQ-011 MUL SHALL use the state sequence IDLE->BUSY at accept; BUSY SHALL last exactly XLEN cycles, with busy=1 throughout; the transition BUSY->IDLE SHALL load the output register and set out_valid; total latency SHALL be XLEN+1.
REQ-012 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-013 On a branch (in_br_e=1), taken SHALL be ans[0]; on a taken branch, redir_pc SHALL be in_pc+in_val and out_ans SHALL be ans.
REQ-014 On a jump (in_jp_e=1), redir_pc SHALL be ans and out_ans SHALL be in_pc+4, the link value.
REQ-015 If in_br_e and in_jp_e are both set, in_br_e SHALL take precedence.
REQ-016 redir_e SHALL pulse for exactly one cycle, coincident with the first out_valid cycle of a taken branch or any jump, and SHALL NOT repeat during a downstream stall.
REQ-017 bp_we SHALL pulse for one cycle for every branch, whether taken or not; bp_tag and bp_taken SHALL be valid during that pulse.
REQ-018 ex_fwd_idx SHALL equal out_rd when out_valid && out_wb_e && out_rd!=0, and 0 otherwise; ex_fwd_val SHALL equal out_ans.
REQ-019 flush SHALL take effect at the next edge: BUSY->IDLE, out_valid=0, and no redir_e or bp_we pulse.
REQ-020 flush SHALL have priority over any simultaneous accept or multiply completion.
REQ-021 Memory control signals and out_val SHALL be forwarded unchanged alongside the result.

Reset
REQ-022 On rst assertion, the block SHALL immediately enter state IDLE and drive out_valid, redir_e, bp_we, bp_taken, busy, out_wb_e, out_mem_e, out_mem_len, out_rd and ex_fwd_idx to 0, and out_ans, out_val and redir_pc to 0.
REQ-023 A reset asserted mid-multiply SHALL discard the operation; after release, in_ready SHALL be 1 on the first cycle.

Structure
REQ-024 Package ex_pkg SHALL hold the opcode constants, the ALUOP_W=5 width and the default XLEN.
REQ-025 The iterative shift-add multiplier SHALL be the single sub-module mul_iter, with ports start, A, B, done and P.
REQ-026 Operand forwarding, the single-cycle ALU and the control FSM SHALL live in ex_stage_hs.

Verification
REQ-027 ADD with opr1=5 and opr2=7, out_ready=1, SHALL give out_ans=12 one cycle after accept, with ex_fwd_idx=in_rd.
REQ-028 rs1=3 with fwd0 (idx 3, value 100) and fwd1 (idx 3, value 200), op ADD with B=1, SHALL give 101; with rs1=0, the result SHALL use in_opr1.
REQ-029 MUL 0xFFFFFFFF*2 at XLEN=32 SHALL give out_valid after 33 cycles with out_ans=0xFFFFFFFE, busy=1 for 32 cycles and in_ready=0 throughout.
REQ-030 A BEQ with equal operands, pc=0x100 and val=0x20 SHALL give redir_e=1 for one cycle with redir_pc=0x120, bp_we=1, bp_taken=1 and bp_tag=0x100; holding out_ready=0 for 3 cycles SHALL produce no second pulse.
REQ-031 A JAL with A=0x400, pc=0x80 and op ADD with B=0 SHALL give redir_pc=0x400 and out_ans=0x84.
REQ-032 flush asserted in the 10th cycle of BUSY SHALL give out_valid=0, no redir_e pulse, and in_ready=1 on the next cycle; rst asserted during BUSY SHALL behave likewise.

Source files
------------

// File: rtl/ex_pkg.sv
// ============================================================================
// Package : ex_pkg
// Brief   : Opcode constants, widths and FSM state type for the execute stage.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam int ALUOP_W  = 5;
    localparam int XLEN_DEF = 32;

    localparam logic [ALUOP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [ALUOP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [ALUOP_W-1:0] OP_SLL  = 5'd2;
    localparam logic [ALUOP_W-1:0] OP_SLT  = 5'd3;
    localparam logic [ALUOP_W-1:0] OP_SLTU = 5'd4;
    localparam logic [ALUOP_W-1:0] OP_XOR  = 5'd5;
    localparam logic [ALUOP_W-1:0] OP_SRL  = 5'd6;
    localparam logic [ALUOP_W-1:0] OP_SRA  = 5'd7;
    localparam logic [ALUOP_W-1:0] OP_OR   = 5'd8;
    localparam logic [ALUOP_W-1:0] OP_AND  = 5'd9;
    localparam logic [ALUOP_W-1:0] OP_EQ   = 5'd10;
    localparam logic [ALUOP_W-1:0] OP_NE   = 5'd11;
    localparam logic [ALUOP_W-1:0] OP_LT   = 5'd12;
    localparam logic [ALUOP_W-1:0] OP_GE   = 5'd13;
    localparam logic [ALUOP_W-1:0] OP_LTU  = 5'd14;
    localparam logic [ALUOP_W-1:0] OP_GEU  = 5'd15;
    localparam logic [ALUOP_W-1:0] OP_MUL  = 5'd16;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ex_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_stage_hs_mul_iter.sv
// ============================================================================
// Module : mul_iter
// Brief  : Iterative shift-add multiplier, one partial product per cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            done,
    output logic [XLEN-1:0] P
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_run;
    logic [XLEN-1:0] w_part;

    // P includes the final partial product so done and P line up in the last cycle
    assign w_part = r_b[0] ? r_a : '0;
    assign P      = r_acc + w_part;
    assign done   = r_run && (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_acc <= '0;
            r_a   <= A;
            r_b   <= B;
            r_cnt <= CW'(XLEN);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= P;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - CW'(1);
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage_hs.sv
// ============================================================================
// Module : ex_stage_hs
// Brief  : Handshaked execute stage: forwarding, ALU, iterative MUL, branch/jump.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_hs
    import ex_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NFWD     = 2,
    parameter int BP_TAG_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [ALUOP_W-1:0]   in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [XLEN-1:0]      in_opr1,
    input  logic [XLEN-1:0]      in_opr2,
    input  logic [XLEN-1:0]      in_val,
    input  logic                 in_wb_e,
    input  logic                 in_br_e,
    input  logic                 in_jp_e,
    input  logic [1:0]           in_mem_e,
    input  logic [1:0]           in_mem_len,
    input  logic [NFWD-1:0]      fwd_vld,
    input  logic [5*NFWD-1:0]    fwd_idx,
    input  logic [XLEN*NFWD-1:0] fwd_val,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_ans,
    output logic [XLEN-1:0]      out_val,
    output logic [4:0]           out_rd,
    output logic                 out_wb_e,
    output logic [1:0]           out_mem_e,
    output logic [1:0]           out_mem_len,
    output logic                 redir_e,
    output logic [XLEN-1:0]      redir_pc,
    output logic                 bp_we,
    output logic [BP_TAG_W-1:0]  bp_tag,
    output logic                 bp_taken,
    output logic [4:0]           ex_fwd_idx,
    output logic [XLEN-1:0]      ex_fwd_val,
    output logic                 busy
);

    localparam int SHW = $clog2(XLEN);

    ex_state_t       r_state;
    ex_state_t       w_state_nxt;
    logic            w_accept;
    logic            w_mul_start;
    logic            w_mul_done;
    logic            w_load;
    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_opb;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_mul_p;

    // Instruction fields held across the multiply
    logic [XLEN-1:0] r_h_pc;
    logic [XLEN-1:0] r_h_val;
    logic [4:0]      r_h_rd;
    logic            r_h_wb;
    logic            r_h_br;
    logic            r_h_jp;
    logic [1:0]      r_h_mem_e;
    logic [1:0]      r_h_mem_len;

    logic            w_from_mul;
    logic [XLEN-1:0] w_f_raw;
    logic [XLEN-1:0] w_f_pc;
    logic [XLEN-1:0] w_f_val;
    logic            w_f_br;
    logic            w_f_jp;
    logic [XLEN-1:0] w_f_ans;
    logic [XLEN-1:0] w_f_rpc;
    logic            w_f_redir;
    logic            w_f_taken;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_ans;
    logic [XLEN-1:0] r_out_val;
    logic [4:0]      r_out_rd;
    logic            r_out_wb_e;
    logic [1:0]      r_out_mem_e;
    logic [1:0]      r_out_mem_len;
    logic            r_redir_e;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_bp_we;
    logic [BP_TAG_W-1:0] r_bp_tag;
    logic            r_bp_taken;

    assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (in_op == OP_MUL);
    assign w_load      = !flush && ((w_accept && (in_op != OP_MUL)) ||
                                    ((r_state == S_BUSY) && w_mul_done));

    // Lowest-index source is applied last so it wins
    always_comb begin
        w_opa = in_opr1;
        w_opb = in_opr2;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if ((in_rs1 != 5'd0) && fwd_vld[i] && (fwd_idx[5*i +: 5] == in_rs1)) begin
                w_opa = fwd_val[XLEN*i +: XLEN];
            end
            if ((in_rs2 != 5'd0) && fwd_vld[i] && (fwd_idx[5*i +: 5] == in_rs2)) begin
                w_opb = fwd_val[XLEN*i +: XLEN];
            end
        end
    end

    assign w_shamt = w_opb[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (in_op)
            OP_ADD:  w_alu = w_opa + w_opb;
            OP_SUB:  w_alu = w_opa - w_opb;
            OP_SLL:  w_alu = w_opa << w_shamt;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_opa) < $signed(w_opb)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_opa < w_opb};
            OP_XOR:  w_alu = w_opa ^ w_opb;
            OP_SRL:  w_alu = w_opa >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(w_opa) >>> w_shamt);
            OP_OR:   w_alu = w_opa | w_opb;
            OP_AND:  w_alu = w_opa & w_opb;
            OP_EQ:   w_alu = {{(XLEN-1){1'b0}}, w_opa == w_opb};
            OP_NE:   w_alu = {{(XLEN-1){1'b0}}, w_opa != w_opb};
            OP_LT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_opa) < $signed(w_opb)};
            OP_GE:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_opa) >= $signed(w_opb)};
            OP_LTU:  w_alu = {{(XLEN-1){1'b0}}, w_opa < w_opb};
            OP_GEU:  w_alu = {{(XLEN-1){1'b0}}, w_opa >= w_opb};
            default: w_alu = '0;
        endcase
    end

    mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .A     (w_opa),
        .B     (w_opb),
        .done  (w_mul_done),
        .P     (w_mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_mul_start) w_state_nxt = S_BUSY;
                S_BUSY:  if (w_mul_done)  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_pc      <= '0;
            r_h_val     <= '0;
            r_h_rd      <= '0;
            r_h_wb      <= 1'b0;
            r_h_br      <= 1'b0;
            r_h_jp      <= 1'b0;
            r_h_mem_e   <= '0;
            r_h_mem_len <= '0;
        end else if (w_mul_start) begin
            r_h_pc      <= in_pc;
            r_h_val     <= in_val;
            r_h_rd      <= in_rd;
            r_h_wb      <= in_wb_e;
            r_h_br      <= in_br_e;
            r_h_jp      <= in_jp_e;
            r_h_mem_e   <= in_mem_e;
            r_h_mem_len <= in_mem_len;
        end
    end

    // Result finishing shared by single-cycle ops and multiply completion
    always_comb begin
        w_from_mul = (r_state == S_BUSY);
        w_f_raw    = w_from_mul ? w_mul_p : w_alu;
        w_f_pc     = w_from_mul ? r_h_pc  : in_pc;
        w_f_val    = w_from_mul ? r_h_val : in_val;
        w_f_br     = w_from_mul ? r_h_br  : in_br_e;
        w_f_jp     = w_from_mul ? r_h_jp  : in_jp_e;
        w_f_ans    = w_f_raw;
        w_f_rpc    = w_f_pc + w_f_val;
        w_f_redir  = 1'b0;
        w_f_taken  = 1'b0;
        if (w_f_br) begin
            w_f_taken = w_f_raw[0];
            w_f_redir = w_f_raw[0];
        end else if (w_f_jp) begin
            w_f_redir = 1'b1;
            w_f_rpc   = w_f_raw;
            w_f_ans   = w_f_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_ans     <= '0;
            r_out_val     <= '0;
            r_out_rd      <= '0;
            r_out_wb_e    <= 1'b0;
            r_out_mem_e   <= '0;
            r_out_mem_len <= '0;
            r_redir_e     <= 1'b0;
            r_redir_pc    <= '0;
            r_bp_we       <= 1'b0;
            r_bp_tag      <= '0;
            r_bp_taken    <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_redir_e   <= 1'b0;
            r_bp_we     <= 1'b0;
        end else begin
            r_redir_e <= 1'b0;
            r_bp_we   <= 1'b0;
            if (w_load) begin
                r_out_valid   <= 1'b1;
                r_out_ans     <= w_f_ans;
                r_out_val     <= w_f_val;
                r_out_rd      <= w_from_mul ? r_h_rd      : in_rd;
                r_out_wb_e    <= w_from_mul ? r_h_wb      : in_wb_e;
                r_out_mem_e   <= w_from_mul ? r_h_mem_e   : in_mem_e;
                r_out_mem_len <= w_from_mul ? r_h_mem_len : in_mem_len;
                r_redir_e     <= w_f_redir;
                r_redir_pc    <= w_f_rpc;
                r_bp_we       <= w_f_br;
                r_bp_tag      <= w_f_pc[BP_TAG_W-1:0];
                r_bp_taken    <= w_f_taken;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_ans     = r_out_ans;
    assign out_val     = r_out_val;
    assign out_rd      = r_out_rd;
    assign out_wb_e    = r_out_wb_e;
    assign out_mem_e   = r_out_mem_e;
    assign out_mem_len = r_out_mem_len;
    assign redir_e     = r_redir_e;
    assign redir_pc    = r_redir_pc;
    assign bp_we       = r_bp_we;
    assign bp_tag      = r_bp_tag;
    assign bp_taken    = r_bp_taken;
    assign ex_fwd_idx  = (r_out_valid && r_out_wb_e && (r_out_rd != 5'd0)) ? r_out_rd : 5'd0;
    assign ex_fwd_val  = r_out_ans;
    assign busy        = (r_state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_hs.sv
// ============================================================================
// Module : tb_ex_stage_hs
// Brief  : Self-checking bench for ex_stage_hs with a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_hs;

    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int BPW  = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [4:0]      in_op;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [31:0]     in_opr1;
    logic [31:0]     in_opr2;
    logic [31:0]     in_val;
    logic            in_wb_e;
    logic            in_br_e;
    logic            in_jp_e;
    logic [1:0]      in_mem_e;
    logic [1:0]      in_mem_len;
    logic [1:0]      fwd_vld;
    logic [9:0]      fwd_idx;
    logic [63:0]     fwd_val;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ans;
    logic [31:0]     out_val;
    logic [4:0]      out_rd;
    logic            out_wb_e;
    logic [1:0]      out_mem_e;
    logic [1:0]      out_mem_len;
    logic            redir_e;
    logic [31:0]     redir_pc;
    logic            bp_we;
    logic [BPW-1:0]  bp_tag;
    logic            bp_taken;
    logic [4:0]      ex_fwd_idx;
    logic [31:0]     ex_fwd_val;
    logic            busy;

    always #5 clk = ~clk;

    ex_stage_hs #(
        .XLEN     (XLEN),
        .NFWD     (NFWD),
        .BP_TAG_W (BPW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_opr1     (in_opr1),
        .in_opr2     (in_opr2),
        .in_val      (in_val),
        .in_wb_e     (in_wb_e),
        .in_br_e     (in_br_e),
        .in_jp_e     (in_jp_e),
        .in_mem_e    (in_mem_e),
        .in_mem_len  (in_mem_len),
        .fwd_vld     (fwd_vld),
        .fwd_idx     (fwd_idx),
        .fwd_val     (fwd_val),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ans     (out_ans),
        .out_val     (out_val),
        .out_rd      (out_rd),
        .out_wb_e    (out_wb_e),
        .out_mem_e   (out_mem_e),
        .out_mem_len (out_mem_len),
        .redir_e     (redir_e),
        .redir_pc    (redir_pc),
        .bp_we       (bp_we),
        .bp_tag      (bp_tag),
        .bp_taken    (bp_taken),
        .ex_fwd_idx  (ex_fwd_idx),
        .ex_fwd_val  (ex_fwd_val),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [31:0] ans;
        logic [31:0] val;
        logic [31:0] rpc;
        logic [4:0]  rd;
        logic        wb;
        logic        br;
        logic        redir;
        logic        taken;
        logic [1:0]  me;
        logic [1:0]  ml;
        logic [9:0]  tag;
    } tx_t;

    function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        for (int i = 0; i < NFWD; i++)
            if (fwd_vld[i] && fwd_idx[5*i +: 5] == rs) return fwd_val[32*i +: 32];
        return rf;
    endfunction

    function automatic tx_t model_tx();
        tx_t t;
        logic [31:0] a, b, r;
        logic [4:0]  sh;
        a  = pick(in_rs1, in_opr1);
        b  = pick(in_rs2, in_opr2);
        sh = b[4:0];
        case (in_op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << sh;
            5'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> sh;
            5'd7:  r = $unsigned($signed(a) >>> sh);
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = (a == b) ? 32'd1 : 32'd0;
            5'd11: r = (a != b) ? 32'd1 : 32'd0;
            5'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd13: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            5'd14: r = (a < b) ? 32'd1 : 32'd0;
            5'd15: r = (a >= b) ? 32'd1 : 32'd0;
            5'd16: r = a * b;
            default: r = 32'd0;
        endcase
        t.val = in_val; t.rd = in_rd; t.wb = in_wb_e; t.me = in_mem_e; t.ml = in_mem_len;
        t.tag = in_pc[9:0]; t.br = in_br_e; t.ans = r; t.rpc = 32'd0;
        t.redir = 1'b0; t.taken = 1'b0;
        if (in_br_e) begin
            t.taken = r[0];
            t.redir = r[0];
            t.rpc   = in_pc + in_val;
        end else if (in_jp_e) begin
            t.redir = 1'b1;
            t.rpc   = r;
            t.ans   = in_pc + 32'd4;
        end
        return t;
    endfunction

    bit  m_busy, m_valid, m_first, m_rdy;
    int  m_left;
    tx_t m_mul, m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_first = 0; m_left = 0;
        end else begin
            m_rdy   = !m_busy && (!m_valid || out_ready) && !flush;
            m_first = 0;
            if (flush) begin
                m_valid = 0;
                m_busy  = 0;
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0; m_valid = 1; m_first = 1; m_out = m_mul;
                    end
                end else if (in_valid && m_rdy) begin
                    if (in_op == 5'd16) begin
                        m_busy = 1; m_left = XLEN; m_mul = model_tx();
                    end else begin
                        m_valid = 1; m_first = 1; m_out = model_tx();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, !m_busy && (!m_valid || out_ready) && !flush);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, m_valid);
            chk("redir_e", redir_e, m_valid && m_first && m_out.redir);
            chk("bp_we", bp_we, m_valid && m_first && m_out.br);
            chk("ex_fwd_idx", ex_fwd_idx,
                (m_valid && m_out.wb && m_out.rd != 0) ? m_out.rd : 5'd0);
            if (m_valid) begin
                chk("out_ans", out_ans, m_out.ans);
                chk("ex_fwd_val", ex_fwd_val, m_out.ans);
                chk("out_val", out_val, m_out.val);
                chk("out_rd", out_rd, m_out.rd);
                chk("out_wb_e", out_wb_e, m_out.wb);
                chk("out_mem_e", out_mem_e, m_out.me);
                chk("out_mem_len", out_mem_len, m_out.ml);
                if (m_out.redir) chk("redir_pc", redir_pc, m_out.rpc);
                if (m_out.br) begin
                    chk("bp_tag", bp_tag, m_out.tag);
                    chk("bp_taken", bp_taken, m_out.taken);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op = op; in_opr1 = a; in_opr2 = b; in_rs1 = 0; in_rs2 = 0;
        in_rd = 5'd5; in_wb_e = 1; in_br_e = 0; in_jp_e = 0;
        in_pc = 32'h200; in_val = a ^ b; in_mem_e = 2'd1; in_mem_len = 2'd2;
    endtask

    task automatic fire();
        int t = 0;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;
    vec_t vecs[17];

    initial begin
        vecs[0]  = '{5'd1,  32'd3,         32'd5, 32'hFFFFFFFE};
        vecs[1]  = '{5'd2,  32'd1,         32'd33, 32'd2};
        vecs[2]  = '{5'd3,  32'hFFFFFFFF,  32'd1, 32'd1};
        vecs[3]  = '{5'd4,  32'hFFFFFFFF,  32'd1, 32'd0};
        vecs[4]  = '{5'd5,  32'hF0F0,      32'h0FF0, 32'hFF00};
        vecs[5]  = '{5'd6,  32'h80000000,  32'd4, 32'h08000000};
        vecs[6]  = '{5'd7,  32'h80000000,  32'd4, 32'hF8000000};
        vecs[7]  = '{5'd8,  32'hA,         32'h5, 32'hF};
        vecs[8]  = '{5'd9,  32'hC,         32'hA, 32'h8};
        vecs[9]  = '{5'd10, 32'd7,         32'd7, 32'd1};
        vecs[10] = '{5'd11, 32'd7,         32'd7, 32'd0};
        vecs[11] = '{5'd12, 32'h80000000,  32'd0, 32'd1};
        vecs[12] = '{5'd13, 32'h80000000,  32'd0, 32'd0};
        vecs[13] = '{5'd14, 32'h80000000,  32'd0, 32'd0};
        vecs[14] = '{5'd15, 32'h80000000,  32'd0, 32'd1};
        vecs[15] = '{5'd20, 32'd5,         32'd5, 32'd0};
        vecs[16] = '{5'd0,  32'hFFFFFFFF,  32'd2, 32'd1};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nb, nr, nred, nbp, nv;
        rst = 1; in_valid = 0; flush = 0; out_ready = 1;
        fwd_vld = 0; fwd_idx = 0; fwd_val = 0;
        set_alu(5'd0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_redir_e", redir_e, 0);
        chk("rst_bp_we", bp_we, 0);
        chk("rst_out_ans", out_ans, 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_ex_fwd_idx", ex_fwd_idx, 0);
        @(posedge clk);
        #1 rst = 0;

        // ADD 5+7
        set_alu(5'd0, 32'd5, 32'd7);
        in_rd = 5'd7;
        fire();
        @(negedge clk);
        chk("add_ans", out_ans, 32'd12);
        chk("add_fwd_idx", ex_fwd_idx, 5'd7);

        // forwarding priority
        set_alu(5'd0, 32'd9, 32'd1);
        in_rs1 = 5'd3;
        fwd_vld = 2'b11; fwd_idx = {5'd3, 5'd3}; fwd_val = {32'd200, 32'd100};
        fire();
        @(negedge clk);
        chk("fwd_prio", out_ans, 32'd101);
        fwd_vld = 2'b10;
        fire();
        @(negedge clk);
        chk("fwd_src1", out_ans, 32'd201);
        in_rs1 = 5'd0; fwd_vld = 2'b11;
        fire();
        @(negedge clk);
        chk("fwd_rs0", out_ans, 32'd10);
        fwd_vld = 0;

        // ALU table (last entry ADD wraps)
        for (int i = 0; i < 17; i++) begin
            set_alu(vecs[i].op, vecs[i].a, vecs[i].b);
            in_rd = 5'(i);
            fire();
            @(negedge clk);
            chk($sformatf("alu_vec%0d", i), out_ans, vecs[i].e);
        end
        drain();

        // MUL latency
        set_alu(5'd16, 32'hFFFFFFFF, 32'd2);
        fire();
        cyc = 0; nb = 0; nr = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
            if (in_ready && !out_valid) nr++;
        end while (!out_valid && cyc < 100);
        chk("mul_latency", cyc, 33);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_ready_low", nr, 0);
        chk("mul_ans", out_ans, 32'hFFFFFFFE);
        drain();

        // BEQ taken with downstream stall
        set_alu(5'd10, 32'd5, 32'd5);
        in_pc = 32'h100; in_val = 32'h20; in_br_e = 1; in_wb_e = 0; in_rd = 0;
        out_ready = 0;
        fire();
        nred = 0; nbp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("beq_redir_pc", redir_pc, 32'h120);
                chk("beq_bp_taken", bp_taken, 1);
                chk("beq_bp_tag", bp_tag, 10'h100);
                chk("beq_held_valid", out_valid, 1);
            end
            if (redir_e) nred++;
            if (bp_we) nbp++;
            @(posedge clk);
            #1;
            if (k == 2) out_ready = 1;
        end
        chk("beq_redir_count", nred, 1);
        chk("beq_bp_count", nbp, 1);

        // Branch not taken: bp_we still pulses
        set_alu(5'd11, 32'd5, 32'd5);
        in_pc = 32'h3FC; in_br_e = 1;
        fire();
        @(negedge clk);
        chk("bne_bp_we", bp_we, 1);
        chk("bne_redir_e", redir_e, 0);
        chk("bne_taken", bp_taken, 0);

        // JAL
        set_alu(5'd0, 32'h400, 32'd0);
        in_pc = 32'h80; in_jp_e = 1; in_rd = 5'd1;
        fire();
        @(negedge clk);
        chk("jal_redir_pc", redir_pc, 32'h400);
        chk("jal_link", out_ans, 32'h84);
        chk("jal_redir_e", redir_e, 1);
        drain();

        // flush in the 10th BUSY cycle of a jump-flagged MUL
        set_alu(5'd16, 32'd3, 32'd4);
        in_jp_e = 1;
        fire();
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_busy", busy, 0);
        nred = 0; nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (redir_e) nred++;
            if (out_valid) nv++;
        end
        chk("flush_no_redir", nred, 0);
        chk("flush_no_valid", nv, 0);

        // reset during BUSY
        set_alu(5'd16, 32'd6, 32'd7);
        fire();
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("rst_busy_cleared", busy, 0);
        chk("rst_valid_cleared", out_valid, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("rst_no_valid", nv, 0);

        // operation after reset release
        set_alu(5'd1, 32'd10, 32'd4);
        fire();
        @(negedge clk);
        chk("post_rst_sub", out_ans, 32'd6);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
